// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
// Op encodings match the RISC-V M-extension funct3 low bits for DIV/DIVU/REM/REMU.
package div_pkg;
  localparam int XLEN = 32;
  localparam int DIV_ITERS = 32;
  localparam logic [XLEN-1:0] DBZ_QUOT = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PREP = 2'b01,
    S_CALC = 2'b10,
    S_DONE = 2'b11
  } div_state_e;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  function automatic logic op_signed(input div_op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_rem(input div_op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic [XLEN-1:0] neg2c(input logic [XLEN-1:0] x);
    return ~x + 1'b1;
  endfunction
endpackage

// File: rtl/adder_subtractor_32bit.sv
// Combinational 32-bit adder/subtractor; o_carry is the no-borrow flag when subtracting.
// Zero latency, no flow control.
module adder_subtractor_32bit #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic            i_sub,
  output logic [XLEN-1:0] o_sum,
  output logic            o_carry,
  output logic            o_ovf
);
  logic [XLEN-1:0] w_b;
  logic [XLEN:0]   w_full;

  assign w_b     = i_sub ? ~i_b : i_b;
  assign w_full  = {1'b0, i_a} + {1'b0, w_b} + (XLEN + 1)'(i_sub);
  assign o_sum   = w_full[XLEN-1:0];
  assign o_carry = w_full[XLEN];
  assign o_ovf   = (i_a[XLEN-1] == w_b[XLEN-1]) && (o_sum[XLEN-1] != i_a[XLEN-1]);
endmodule

// File: rtl/div_seq_32bit.sv
// Restoring divider (DIV/DIVU/REM/REMU): 34 cycles start-to-valid, 2 for div-by-zero/overflow.
// No backpressure: i_start is ignored while busy, i_kill aborts back to IDLE.
module div_seq_32bit
  import div_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic            i_kill,
  output logic            o_busy,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result,
  output logic            o_dbz
);
  localparam int CNT_W = $clog2(XLEN);

  div_state_e      r_state;
  div_op_e         r_op;
  logic [XLEN-1:0] r_a, r_b, r_q, r_r, r_result;
  logic [CNT_W-1:0] r_cnt;
  logic            r_neg_q, r_neg_r, r_busy, r_valid, r_dbz;

  logic            w_sgn, w_rem;
  logic [XLEN-1:0] w_abs_a, w_abs_b, w_shifted, w_diff, w_r_nxt, w_q_nxt, w_quot, w_remd;
  logic            w_carry, w_acc;

  assign w_sgn   = op_signed(r_op);
  assign w_rem   = op_rem(r_op);
  assign w_abs_a = (w_sgn && r_a[XLEN-1]) ? neg2c(r_a) : r_a;
  assign w_abs_b = (w_sgn && r_b[XLEN-1]) ? neg2c(r_b) : r_b;

  // The bit shifted out of R makes the partial remainder 33 bits wide; it always exceeds |b|.
  assign w_shifted = {r_r[XLEN-2:0], r_q[XLEN-1]};
  assign w_acc     = w_carry | r_r[XLEN-1];
  assign w_r_nxt   = w_acc ? w_diff : w_shifted;
  assign w_q_nxt   = {r_q[XLEN-2:0], w_acc};
  assign w_quot    = r_neg_q ? neg2c(w_q_nxt) : w_q_nxt;
  assign w_remd    = r_neg_r ? neg2c(w_r_nxt) : w_r_nxt;

  adder_subtractor_32bit #(.XLEN(XLEN)) u_addsub (
    .i_a     (w_shifted),
    .i_b     (r_b),
    .i_sub   (1'b1),
    .o_sum   (w_diff),
    .o_carry (w_carry),
    .o_ovf   ()
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_op     <= OP_DIV;
      r_a      <= '0;
      r_b      <= '0;
      r_q      <= '0;
      r_r      <= '0;
      r_cnt    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_result <= '0;
      r_dbz    <= 1'b0;
    end else if (i_kill) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_valid <= 1'b0;
          if (i_start) begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_op    <= div_op_e'(i_op);
            r_dbz   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_PREP;
          end
        end
        S_PREP: begin
          r_neg_q <= w_sgn & (r_a[XLEN-1] ^ r_b[XLEN-1]);
          r_neg_r <= w_sgn & r_a[XLEN-1];
          r_q     <= w_abs_a;
          r_b     <= w_abs_b;
          r_r     <= '0;
          r_cnt   <= CNT_W'(DIV_ITERS - 1);
          if (r_b == '0) begin
            r_result <= w_rem ? r_a : DBZ_QUOT;
            r_dbz    <= 1'b1;
            r_busy   <= 1'b0;
            r_valid  <= 1'b1;
            r_state  <= S_DONE;
          end else if (w_sgn && (r_a == INT_MIN) && (r_b == '1)) begin
            r_result <= w_rem ? '0 : INT_MIN;
            r_busy   <= 1'b0;
            r_valid  <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_r   <= w_r_nxt;
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_result <= w_rem ? w_remd : w_quot;
            r_busy   <= 1'b0;
            r_valid  <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy   = r_busy;
  assign o_valid  = r_valid;
  assign o_result = r_result;
  assign o_dbz    = r_dbz;
endmodule

// File: tb/tb_div_seq_32bit.sv
// Directed-vector bench for div_seq_32bit: results, latencies, abort and reset behaviour.
module tb_div_seq_32bit;
  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_start = 1'b0;
  logic [1:0]  i_op = 2'b00;
  logic [31:0] i_a = '0;
  logic [31:0] i_b = '0;
  logic        i_kill = 1'b0;
  logic        o_busy, o_valid, o_dbz;
  logic [31:0] o_result;

  int n_chk = 0;
  int n_err = 0;

  div_seq_32bit dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_start  (i_start),
    .i_op     (i_op),
    .i_a      (i_a),
    .i_b      (i_b),
    .i_kill   (i_kill),
    .o_busy   (o_busy),
    .o_valid  (o_valid),
    .o_result (o_result),
    .o_dbz    (o_dbz)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Returns at the falling edge of cycle T+1, where T is the edge that samples i_start.
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge i_clk);
    i_op = op; i_a = a; i_b = b; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  task automatic do_div(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input logic exp_dbz, input int exp_lat);
    int  k;
    bit  busy_bad;
    start_op(op, a, b);
    k = 1;
    busy_bad = 0;
    while (k <= 60 && !o_valid) begin
      if (!o_busy) busy_bad = 1;
      @(negedge i_clk);
      k++;
    end
    chk({tag, "_lat"}, 32'(k), 32'(exp_lat));
    chk({tag, "_busy"}, {31'b0, busy_bad}, 32'd0);
    chk({tag, "_res"}, o_result, exp_res);
    chk({tag, "_dbz"}, {31'b0, o_dbz}, {31'b0, exp_dbz});
    chk({tag, "_busy_done"}, {31'b0, o_busy}, 32'd0);
  endtask

  initial begin
    int nv;
    repeat (2) @(negedge i_clk);
    chk("rst_busy", {31'b0, o_busy}, 32'd0);
    chk("rst_valid", {31'b0, o_valid}, 32'd0);
    chk("rst_result", o_result, 32'd0);
    chk("rst_dbz", {31'b0, o_dbz}, 32'd0);
    i_rst = 1'b0;

    do_div("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, 1'b0, 34);
    do_div("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 1'b0, 34);
    do_div("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 34);
    do_div("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 34);
    do_div("div_7_m2", 2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 34);
    do_div("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0, 34);
    do_div("divu_dbz", 2'b01, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 1'b1, 2);
    do_div("rem_dbz", 2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1'b1, 2);
    do_div("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 2);
    do_div("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 2);
    do_div("divu_big", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 1'b0, 34);
    do_div("remu_big", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 1'b0, 34);
    do_div("divu_1000_10", 2'b01, 32'd1000, 32'd10, 32'd100, 1'b0, 34);

    // Start pulses while busy must not disturb the running divide or queue another.
    start_op(2'b01, 32'd100, 32'd7);
    repeat (4) @(negedge i_clk);
    i_op = 2'b01; i_a = 32'd50; i_b = 32'd5; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    nv = 6;
    while (nv <= 60 && !o_valid) begin
      @(negedge i_clk);
      nv++;
    end
    chk("ign_lat", 32'(nv), 32'd34);
    chk("ign_res", o_result, 32'd14);
    @(negedge i_clk);
    chk("ign_noqueue", {31'b0, o_busy}, 32'd0);

    // Kill at T+10: IDLE at T+11, no valid, old result held.
    start_op(2'b01, 32'd200, 32'd3);
    repeat (9) @(negedge i_clk);
    i_kill = 1'b1;
    @(negedge i_clk);
    i_kill = 1'b0;
    chk("kill_busy", {31'b0, o_busy}, 32'd0);
    nv = 0;
    repeat (40) begin
      if (o_valid) nv++;
      @(negedge i_clk);
    end
    chk("kill_novalid", 32'(nv), 32'd0);
    chk("kill_hold", o_result, 32'd14);

    // Kill wins over start in IDLE.
    i_op = 2'b01; i_a = 32'd9; i_b = 32'd3; i_start = 1'b1; i_kill = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0; i_kill = 1'b0;
    chk("kill_prio", {31'b0, o_busy}, 32'd0);

    // Asynchronous reset at T+20 clears outputs immediately.
    start_op(2'b00, 32'hFFFF_FFF9, 32'd0);
    @(negedge i_clk);
    start_op(2'b01, 32'd200, 32'd3);
    repeat (19) @(negedge i_clk);
    chk("pre_rst_busy", {31'b0, o_busy}, 32'd1);
    #1 i_rst = 1'b1;
    #1;
    chk("arst_busy", {31'b0, o_busy}, 32'd0);
    chk("arst_valid", {31'b0, o_valid}, 32'd0);
    chk("arst_result", o_result, 32'd0);
    chk("arst_dbz", {31'b0, o_dbz}, 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    do_div("post_rst", 2'b01, 32'd9, 32'd3, 32'd3, 1'b0, 34);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
